// File: rtl/shift_req_scheduler.sv
// shift_req_scheduler: round-robin two-requester front end that iterates a shared barrel shifter
module shift_req_scheduler #(
  parameter int PASS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_data,
  input  logic [1:0]        req0_amt,
  input  logic [PASS_W-1:0] req0_passes,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_data,
  input  logic [1:0]        req1_amt,
  input  logic [PASS_W-1:0] req1_passes,
  output logic [3:0]        sh_i,
  output logic [1:0]        sh_s,
  input  logic [3:0]        sh_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_data,
  output logic              rsp_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        acc_q, acc_d;
  logic [1:0]        amt_q, amt_d;
  logic [PASS_W-1:0] cnt_q, cnt_d;
  logic              id_q, id_d, ptr_q, ptr_d;
  logic              idle, gnt1, take;
  logic [3:0]        dsel;
  logic [1:0]        asel;
  logic [PASS_W-1:0] psel;
  // req1 wins when it is alone or when both ask and the pointer favours it
  assign idle       = state_q == IDLE;
  assign gnt1       = req1_valid & (~req0_valid | ptr_q);
  assign req0_ready = idle & req0_valid & ~gnt1 & ~rst;
  assign req1_ready = idle & gnt1 & ~rst;
  assign take       = req0_ready | req1_ready;
  assign dsel       = gnt1 ? req1_data : req0_data;
  assign asel       = gnt1 ? req1_amt : req0_amt;
  assign psel       = gnt1 ? req1_passes : req0_passes;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state: a zero-pass job skips RUN so the operand returns unmodified
  always_comb begin
    state_d = state_q;
    if (take) state_d = (psel == '0) ? DONE : RUN;
    else if (state_q == RUN && cnt_q == PASS_W'(1)) state_d = DONE;
    else if (state_q == DONE && rsp_ready) state_d = IDLE;
  end
  // outputs come straight from registers, so rsp_ready never reaches them combinationally
  always_comb begin
    busy      = ~idle;
    rsp_valid = state_q == DONE;
    sh_i      = acc_q;
    sh_s      = amt_q;
    rsp_data  = acc_q;
    rsp_id    = id_q;
  end
  // datapath next-state: load on acceptance, feed the shifter result back each RUN pass
  always_comb begin
    acc_d = acc_q;
    amt_d = amt_q;
    cnt_d = cnt_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    if (take) begin
      acc_d = dsel;
      amt_d = asel;
      cnt_d = psel;
      id_d  = gnt1;
      ptr_d = ~gnt1;
    end else if (state_q == RUN) begin
      acc_d = sh_o;
      cnt_d = cnt_q - PASS_W'(1);
    end
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      amt_q <= '0;
      cnt_q <= '0;
      id_q  <= 1'b0;
      ptr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      amt_q <= amt_d;
      cnt_q <= cnt_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_shift_req_scheduler.sv
// tb_shift_req_scheduler: directed and random jobs checked against a rotate-by-total-amount model
module tb_shift_req_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_ready, req1_ready;
  logic [3:0] sh_i, sh_o, rsp_data;
  logic [1:0] sh_s;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic       v [2];
  logic [3:0] d [2];
  logic [1:0] a [2];
  logic [2:0] p [2];
  int         errors = 0;
  int         checks = 0;
  int         mptr = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rotl(input logic [3:0] x, input int s);
    logic [7:0] t;
    t = {x, x} << (s % 4);
    return t[7:4];
  endfunction

  assign sh_o = rotl(sh_i, int'(sh_s));

  shift_req_scheduler #(.PASS_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_data(d[0]), .req0_amt(a[0]), .req0_passes(p[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_data(d[1]), .req1_amt(a[1]), .req1_passes(p[1]),
    .sh_i(sh_i), .sh_s(sh_s), .sh_o(sh_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with valids/payloads already set; serves one job end to end.
  task automatic serve(input int hold);
    int g, lat;
    logic [3:0] ed, er;
    logic [1:0] ea;
    logic [2:0] ep;
    g  = (v[0] && v[1]) ? mptr : (v[1] ? 1 : 0);
    ed = d[g];
    ea = a[g];
    ep = p[g];
    er = rotl(ed, int'(ea) * int'(ep));
    #1;
    check("ready0", 32'(req0_ready), 32'(g == 0));
    check("ready1", 32'(req1_ready), 32'(g == 1));
    @(posedge clk); #1;
    v[g] = 1'b0;
    mptr = 1 - g;
    lat  = 0;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!rsp_valid && lat < 40) begin
      check("sh_i_pass", 32'(sh_i), 32'(rotl(ed, int'(ea) * lat)));
      check("sh_s_pass", 32'(sh_s), 32'(ea));
      check("ready_in_run", 32'(req0_ready | req1_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(ep));
    check("rsp_data", 32'(rsp_data), 32'(er));
    check("rsp_id", 32'(rsp_id), 32'(g));
    for (int i = 0; i < hold; i++) begin
      if (!v[1-g]) v[1-g] = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(er));
      check("hold_ready", 32'(req0_ready | req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("busy_after_rsp", 32'(busy), 32'd0);
    check("valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    v[0] = 1'b1; d[0] = 4'b0001; a[0] = 2'd2; p[0] = 3'd1;
    v[1] = 1'b1; d[1] = 4'b1000; a[1] = 2'd2; p[1] = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sh", 32'({sh_i, sh_s}), 32'd0);
    check("rst_rsp", 32'({rsp_data, rsp_id}), 32'd0);
    rst = 1'b0;
    mptr = 0;
    serve(0);
    serve(0);
    v[0] = 1'b1; d[0] = 4'b0101; a[0] = 2'd1; p[0] = 3'd2;
    v[1] = 1'b1; d[1] = 4'b0011; a[1] = 2'd3; p[1] = 3'd2;
    serve(0);
    serve(0);
    v[0] = 1'b1; d[0] = 4'b1001; a[0] = 2'd1; p[0] = 3'd1;
    serve(0);
    v[1] = 1'b1; d[1] = 4'b1001; a[1] = 2'd1; p[1] = 3'd3;
    serve(0);
    v[1] = 1'b1; d[1] = 4'b1010; a[1] = 2'd3; p[1] = 3'd0;
    serve(5);
    d[0] = 4'b0110; a[0] = 2'd1; p[0] = 3'd7;
    #1;
    check("long_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    v[1] = 1'b1;
    #1;
    check("rst_run_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    check("rst_drop_valid", 32'(rsp_valid), 32'd0);
    check("rst_drop_busy", 32'(busy), 32'd0);
    check("rst_drop_sh_i", 32'(sh_i), 32'd0);
    check("rst_drop_rsp", 32'({rsp_data, rsp_id, sh_s}), 32'd0);
    check("rst_idle_ready", 32'({req0_ready, req1_ready}), 32'd0);
    rst = 1'b0;
    v[1] = 1'b0;
    mptr = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_rsp_after_drop", 32'({rsp_valid, busy}), 32'd0);
    end
    v[0] = 1'b1; d[0] = 4'b1100; a[0] = 2'd3; p[0] = 3'd2;
    serve(1);
    for (int j = 0; j < 25; j++) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] && $urandom_range(0, 1) == 1) begin
          v[r] = 1'b1;
          d[r] = 4'($urandom);
          a[r] = 2'($urandom);
          p[r] = 3'($urandom);
        end
      end
      if (!v[0] && !v[1]) begin
        v[0] = 1'b1;
        d[0] = 4'($urandom);
        a[0] = 2'($urandom);
        p[0] = 3'($urandom);
      end
      serve(int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
